// File: rtl/status_register_pkg.sv
// status_register_pkg: shared flag bit indices, flag word type and save/restore state encoding
package status_register_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
  typedef logic [3:0] sr_t;
  typedef enum logic {IDLE, SAVED} state_t;
endpackage

// File: rtl/status_register_if.sv
// status_register_if: request and flag-view signals between the pipeline and the status register
interface status_register_if
  import status_register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              stall;
  logic              flags_update;
  logic [DATA_W-1:0] alu_result;
  logic              alu_c;
  logic              alu_v;
  logic              msr_we;
  sr_t               msr_data;
  logic              exc_entry;
  logic              exc_return;
  sr_t               sr;
  sr_t               saved_sr;
  logic              saved_valid;
  logic              sr_err;
  modport master (
    output stall, flags_update, alu_result, alu_c, alu_v, msr_we, msr_data, exc_entry, exc_return,
    input  sr, saved_sr, saved_valid, sr_err
  );
  modport slave (
    input  stall, flags_update, alu_result, alu_c, alu_v, msr_we, msr_data, exc_entry, exc_return,
    output sr, saved_sr, saved_valid, sr_err
  );
endinterface

// File: rtl/status_register_flag_gen.sv
// flag_gen: packs {z, c, n, v} from the ALU result and carry/overflow
module flag_gen
  import status_register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_v,
  output sr_t               flags
);
  // z from an all-zero result, n from the sign bit
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = ~|alu_result;
    flags[FLAG_C] = alu_c;
    flags[FLAG_N] = alu_result[DATA_W-1];
    flags[FLAG_V] = alu_v;
  end
endmodule

// File: rtl/status_register.sv
// status_register: condition-flag register with MSR write and single-level exception save/restore
// Optional SR_BYPASS_EN: sr shows the value being written this cycle instead of the register.
module status_register
  import status_register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic rst,
  status_register_if.slave bus
);
  sr_t    gen;
  sr_t    sr_q;
  sr_t    sr_nxt;
  sr_t    saved_q;
  logic   err_q;
  logic   err_nxt;
  state_t state;
  state_t state_nxt;
  logic   saved_valid;
  logic   ret_ok;
  logic   ret_bad;
  logic   ent;
  logic   ent_ok;
  logic   ent_bad;
  logic   wr_msr;
  logic   wr_alu;

  flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .alu_result(bus.alu_result),
    .alu_c     (bus.alu_c),
    .alu_v     (bus.alu_v),
    .flags     (gen)
  );

  // decode the request priority: return, entry, msr, alu flags; a stall blocks everything
  always_comb begin
    ret_ok  = !bus.stall && bus.exc_return && saved_valid;
    ret_bad = !bus.stall && bus.exc_return && !saved_valid;
    ent     = !bus.stall && bus.exc_entry && !bus.exc_return;
    ent_ok  = ent && !saved_valid;
    ent_bad = ent && saved_valid;
    wr_msr  = !bus.stall && !bus.exc_return && !bus.exc_entry && bus.msr_we;
    wr_alu  = !bus.stall && !bus.exc_return && !bus.exc_entry && !bus.msr_we && bus.flags_update;
    sr_nxt  = ret_ok ? saved_q : wr_msr ? bus.msr_data : wr_alu ? gen : sr_q;
    err_nxt = ret_bad || ent_bad;
  end

  // save/restore state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // legal entry arms the saved copy, legal return releases it
  always_comb begin
    state_nxt = ret_ok ? IDLE : ent_ok ? SAVED : state;
  end

  // saved copy is live only in SAVED
  always_comb begin
    saved_valid = (state == SAVED);
  end

  // flag word, saved copy and error pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      saved_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sr_q    <= sr_nxt;
      saved_q <= ent_ok ? sr_q : saved_q;
      err_q   <= err_nxt;
    end
  end

`ifdef SR_BYPASS_EN
  assign bus.sr = sr_nxt;
`else
  assign bus.sr = sr_q;
`endif
  assign bus.saved_sr    = saved_q;
  assign bus.saved_valid = saved_valid;
  assign bus.sr_err      = err_q;
endmodule

// File: tb/tb_status_register.sv
// tb_status_register: directed checks of flag latching, priority, save/restore, errors and reset
module tb_status_register;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  status_register_if #(.DATA_W(32)) bus ();

  status_register #(.DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall        = 1'b0;
    bus.flags_update = 1'b0;
    bus.alu_result   = 32'h1;
    bus.alu_c        = 1'b0;
    bus.alu_v        = 1'b0;
    bus.msr_we       = 1'b0;
    bus.msr_data     = 4'b0000;
    bus.exc_entry    = 1'b0;
    bus.exc_return   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic msr(input logic [3:0] d);
    bus.msr_we   = 1'b1;
    bus.msr_data = d;
    step();
  endtask

  initial begin
    idle();
    #12;
    check("rst_sr", 32'(bus.sr), 32'h0);
    check("rst_saved_sr", 32'(bus.saved_sr), 32'h0);
    check("rst_saved_valid", 32'(bus.saved_valid), 32'h0);
    check("rst_sr_err", 32'(bus.sr_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    bus.flags_update = 1'b1;
    bus.alu_result   = 32'h0;
    bus.alu_c        = 1'b1;
    #1;
`ifdef SR_BYPASS_EN
    check("bypass_same_cycle", 32'(bus.sr), 32'hc);
`else
    check("no_bypass_same_cycle", 32'(bus.sr), 32'h0);
`endif
    step();
    check("alu_zero_carry", 32'(bus.sr), 32'hc);

    bus.stall        = 1'b1;
    bus.flags_update = 1'b1;
    bus.alu_result   = 32'h8000_0000;
    bus.alu_v        = 1'b1;
    @(posedge clk);
    #1;
    check("stall_hold", 32'(bus.sr), 32'hc);
    bus.stall = 1'b0;
    step();
    check("alu_neg_ovf", 32'(bus.sr), 32'h3);

    msr(4'b0101);
    check("msr_0101", 32'(bus.sr), 32'h5);
    bus.exc_entry    = 1'b1;
    bus.flags_update = 1'b1;
    bus.alu_result   = 32'h0;
    step();
    check("entry_saved_sr", 32'(bus.saved_sr), 32'h5);
    check("entry_saved_valid", 32'(bus.saved_valid), 32'h1);
    check("entry_flush_update", 32'(bus.sr), 32'h5);
    msr(4'b1010);
    check("msr_in_handler", 32'(bus.sr), 32'ha);
    bus.exc_return = 1'b1;
    step();
    check("return_sr", 32'(bus.sr), 32'h5);
    check("return_saved_valid", 32'(bus.saved_valid), 32'h0);
    check("return_no_err", 32'(bus.sr_err), 32'h0);

    bus.exc_return = 1'b1;
    step();
    check("bad_return_sr", 32'(bus.sr), 32'h5);
    check("bad_return_err", 32'(bus.sr_err), 32'h1);
    step();
    check("bad_return_err_pulse", 32'(bus.sr_err), 32'h0);
    bus.exc_entry = 1'b1;
    step();
    check("entry2_valid", 32'(bus.saved_valid), 32'h1);
    msr(4'b1111);
    bus.exc_entry = 1'b1;
    step();
    check("nested_saved_sr", 32'(bus.saved_sr), 32'h5);
    check("nested_err", 32'(bus.sr_err), 32'h1);
    check("nested_sr", 32'(bus.sr), 32'hf);
    step();
    check("nested_err_pulse", 32'(bus.sr_err), 32'h0);

    bus.stall      = 1'b1;
    bus.exc_return = 1'b1;
    step();
    check("stall_return_sr", 32'(bus.sr), 32'hf);
    check("stall_return_valid", 32'(bus.saved_valid), 32'h1);
    check("stall_return_err", 32'(bus.sr_err), 32'h0);

    bus.exc_return = 1'b1;
    bus.exc_entry  = 1'b1;
    step();
    check("both_return_sr", 32'(bus.sr), 32'h5);
    check("both_return_valid", 32'(bus.saved_valid), 32'h0);
    check("both_return_err", 32'(bus.sr_err), 32'h0);

    bus.msr_we       = 1'b1;
    bus.msr_data     = 4'b0110;
    bus.flags_update = 1'b1;
    bus.alu_result   = 32'h0;
    step();
    check("msr_over_update", 32'(bus.sr), 32'h6);
    bus.exc_entry = 1'b1;
    step();
    check("entry3_saved_sr", 32'(bus.saved_sr), 32'h6);
    check("entry3_valid", 32'(bus.saved_valid), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_sr", 32'(bus.sr), 32'h0);
    check("async_rst_saved_sr", 32'(bus.saved_sr), 32'h0);
    check("async_rst_saved_valid", 32'(bus.saved_valid), 32'h0);
    check("async_rst_err", 32'(bus.sr_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/status_register.md
# status_register

Writer side of the condition-flag path. Generates the four-bit flag word {z, c, n, v} from the execute-stage ALU result and carry/overflow, latches it when the instruction's S bit is set, and drives `sr` to the condition-check logic in the decode/execute stages. It also supports a direct flag write (MSR-style) and a single-level save/restore of the flags on exception entry and return, with stall and error handling.

## Interface
Parameters:
- `DATA_W`, 32, ALU result width used for N/Z generation.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  pipeline freeze; blocks every update except reset.
- `flags_update`  in  1  S bit of the instruction in execute; request to latch ALU flags.
- `alu_result`  in  DATA_W  execute-stage ALU result.
- `alu_c`  in  1  ALU carry-out.
- `alu_v`  in  1  ALU signed overflow.
- `msr_we`  in  1  direct flag write.
- `msr_data`  in  4  value for direct write, packed {z, c, n, v}.
- `exc_entry`  in  1  exception taken; save flags.
- `exc_return`  in  1  exception return; restore flags.
- `sr`  out  4  current flags, packed {z, c, n, v} (bit 3 = z, bit 0 = v).
- `saved_sr`  out  4  saved copy, same packing.
- `saved_valid`  out  1  saved copy holds live data.
- `sr_err`  out  1  one-cycle pulse: illegal return or nested entry.

## Operation
- Flag generation: n = alu_result[DATA_W-1]; z = (alu_result == 0); c = alu_c; v = alu_v. Packed as {z, c, n, v}.
- Per-cycle priority when `stall`=0, highest first:
  1. `exc_return`: if `saved_valid`=1: sr <= saved_sr, saved_valid <= 0. If `saved_valid`=0: sr unchanged, sr_err pulses.
  2. `exc_entry`: if `saved_valid`=0: saved_sr <= current sr (pre-update value), saved_valid <= 1. Any same-cycle `flags_update`/`msr_we` is discarded because the instruction is flushed. If `saved_valid`=1 (nested): saved copy is kept, sr unchanged, sr_err pulses.
  3. `msr_we`: sr <= msr_data. `flags_update` in the same cycle is ignored.
  4. `flags_update`: sr <= generated flags.
- `exc_entry` and `exc_return` together: return wins and entry is ignored. No error is raised unless the return itself is illegal.
- `stall`=1: all registers hold. `sr_err` is driven to 0. Requests are not queued.
- State view: two states. `IDLE` (saved_valid=0) moves to `SAVED` on a legal entry. `SAVED` moves back to `IDLE` on a legal return.

## Timing
- Reset (asynchronous, immediate): sr=4'b0000, saved_sr=4'b0000, saved_valid=0, sr_err=0. A reset mid-exception drops the saved copy.
- Registered update: a flag write in cycle T is visible on `sr` in cycle T+1.
- `sr_err` is registered: high exactly one cycle after the offending request.
- `saved_sr`/`saved_valid` change one cycle after the entry or return edge.

## Configuration
- `SR_BYPASS_EN` defined:
  - `sr` is combinational: it shows the value that will be latched this cycle (msr_data, generated flags, or saved_sr on a legal return) whenever that write is enabled and not stalled.
  - Otherwise `sr` shows the register.
  - Lets condition check in the same cycle see the flags of the immediately preceding S instruction.
- `SR_BYPASS_EN` undefined: `sr` is the register output only, with one-cycle latency.
- The internal register contents are identical in both builds.

## Structure
- Shared package holds:
  - flag bit-index constants `FLAG_Z`=3, `FLAG_C`=2, `FLAG_N`=1, `FLAG_V`=0;
  - the 4-bit `sr_t` typedef;
  - `DATA_W` default.
- The condition-check logic uses the same package for unpacking.
- One sub-module, `flag_gen`: combinational N/Z/C/V packing from `alu_result`, `alu_c` and `alu_v`. The register and priority logic stay in `status_register`.

## Test plan
- Reset, then flags_update=1 with alu_result=0, alu_c=1, alu_v=0 -> next cycle sr=4'b1100.
- flags_update=1 with alu_result=32'h8000_0000, alu_v=1, stall=1 -> sr holds. Deassert stall -> next cycle sr=4'b0011.
- sr=4'b0101. exc_entry together with flags_update (alu_result=0) -> saved_sr=4'b0101, saved_valid=1, sr stays 4'b0101. msr_we with 4'b1010 -> sr=4'b1010. exc_return -> sr=4'b0101, saved_valid=0.
- exc_return with saved_valid=0 -> sr unchanged, sr_err=1 for exactly one cycle. A second exc_entry while saved_valid=1 -> saved_sr unchanged, sr_err pulse.
- msr_we=1 (4'b0110) with flags_update=1 (alu_result=0) -> sr=4'b0110. Assert rst asynchronously mid-cycle while saved_valid=1 -> all outputs 0 before the next edge.
- With `SR_BYPASS_EN`: flags_update with alu_result=0 -> sr=4'b1x00 in the same cycle. Without the macro, sr changes only after the edge.
